dmem_responder: RTL and testbench

Data-memory responder for the core's data port: it accepts load/store requests on the `mem_*_mem` bus and returns sized, sign- or zero-extended load data. It also drives `stall_pipl` to freeze the pipeline while a synchronous-SRAM read is in flight. It sits directly on the core's memory bus and holds `DMEM_DEPTH` 32-bit words with byte-lane write enables. Accesses that are misaligned or out of range are suppressed and flagged.

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous-SRAM backed load/store port with
// sized/extended load data, a single-cycle load stall and an error pulse
// for suppressed (misaligned, out-of-range or malformed) accesses.
module dmem_responder #(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        access_err
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t        state_q, state_d;

    logic [31:0]   off;
    logic [1:0]    lsb;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          op_ok;
    logic          align_ok;
    logic          any_req;
    logic          illegal;

    logic          rd_fire;
    logic          wr_fire;
    logic          err_d, err_q;
    logic [1:0]    lsb_d, lsb_q;
    logic [2:0]    op_d, op_q;

    logic [3:0]    be;
    logic [31:0]   lanes;

    logic [31:0]   mem_q [DMEM_DEPTH];
    logic [31:0]   sram_word_q;
    logic [31:0]   shifted;
    logic [31:0]   load_fmt;

    // Address decode and legality of the request currently on the bus
    always_comb begin
        off      = mem_addr_mem - BASE_ADDR;
        lsb      = off[1:0];
        word_idx = off[AW+1:2];
        in_range = (off >> (AW + 2)) == 32'd0;

        case (mem_op_mem)
            3'b000, 3'b001, 3'b010: op_ok = 1'b1;
            3'b100, 3'b101:         op_ok = !mem_write_mem;
            default:                op_ok = 1'b0;
        endcase

        case (mem_op_mem[1:0])
            2'b01:   align_ok = !lsb[0];
            2'b10:   align_ok = (lsb == 2'b00);
            default: align_ok = 1'b1;
        endcase

        any_req = mem_read_mem | mem_write_mem;
        illegal = (mem_read_mem & mem_write_mem) | !in_range | !op_ok | !align_ok;
    end

    // Store byte enables and replicated write lanes
    always_comb begin
        case (mem_op_mem[1:0])
            2'b00: begin
                be    = 4'b0001 << lsb;
                lanes = {4{mem_wdata_mem[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lsb;
                lanes = {2{mem_wdata_mem[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                lanes = mem_wdata_mem;
            end
        endcase
    end

    // FSM next state, stall and access strobes; requests seen in RESP are the
    // held load being consumed, so nothing fires there. Gating with reset_n
    // keeps stall low and the array untouched while reset is asserted.
    always_comb begin
        state_d    = state_q;
        stall_pipl = 1'b0;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        err_d      = 1'b0;
        lsb_d      = lsb_q;
        op_d       = op_q;
        case (state_q)
            IDLE: begin
                if (reset_n && any_req) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (mem_read_mem) begin
                        rd_fire    = 1'b1;
                        stall_pipl = 1'b1;
                        lsb_d      = lsb;
                        op_d       = mem_op_mem;
                        state_d    = RESP;
                    end else begin
                        wr_fire = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            lsb_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            lsb_q   <= lsb_d;
            op_q    <= op_d;
        end
    end

    // SRAM array with byte-lane writes and registered read port (not reset)
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= lanes[8*i +: 8];
                end
            end
        end
        if (rd_fire) begin
            sram_word_q <= mem_q[word_idx];
        end
    end

    // Load data alignment and size/sign extension, visible only in RESP
    always_comb begin
        shifted = sram_word_q >> {lsb_q, 3'b000};
        case (op_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_fmt = {24'd0, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_fmt = {16'd0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
        mem_rdata_mem = (state_q == RESP) ? load_fmt : '0;
    end

    assign access_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes per-cycle expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_dmem_responder;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_X  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr_mem;
    logic [31:0] mem_wdata_mem;
    logic        mem_write_mem;
    logic        mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic [31:0] mem_rdata_mem;
    logic        stall_pipl;
    logic        access_err;

    typedef struct packed {
        logic        stall;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_bad = 0;
    logic pend_err = 1'b0;
    logic done = 1'b0;

    dmem_responder #(
        .DMEM_DEPTH (64),
        .BASE_ADDR  (32'h0000_1000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr_mem  (mem_addr_mem),
        .mem_wdata_mem (mem_wdata_mem),
        .mem_write_mem (mem_write_mem),
        .mem_read_mem  (mem_read_mem),
        .mem_op_mem    (mem_op_mem),
        .mem_rdata_mem (mem_rdata_mem),
        .stall_pipl    (stall_pipl),
        .access_err    (access_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, got, want);
        end
    endtask

    // Monitor: compare one expected record per cycle, mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                n_vec++;
                check("stall_pipl", n_vec, {31'd0, stall_pipl}, {31'd0, cur.stall});
                check("mem_rdata_mem", n_vec, mem_rdata_mem, cur.rdata);
                check("access_err", n_vec, {31'd0, access_err}, {31'd0, cur.err});
            end
        end
    end

    // One bus cycle; bad marks the request as one that must raise access_err next cycle
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] op, input logic es, input logic [31:0] ed, input logic bad);
        @(posedge clk);
        #1;
        mem_read_mem  = rd;
        mem_write_mem = wr;
        mem_addr_mem  = a;
        mem_wdata_mem = wd;
        mem_op_mem    = op;
        exp_q.push_back('{stall: es, rdata: ed, err: pend_err});
        pend_err = bad;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        cyc(1'b0, 1'b1, a, d, op, 1'b0, 32'd0, 1'b0);
    endtask

    // Load: stall cycle, then the held request is consumed while data is shown
    task automatic load(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, 32'd0, op, 1'b1, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, a, 32'd0, op, 1'b0, d, 1'b0);
    endtask

    task automatic bad(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        cyc(rd, wr, a, d, op, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 32'd0, OP_W, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_read_mem  = 1'b1;
        mem_write_mem = 1'b0;
        mem_addr_mem  = 32'h0000_1010;
        mem_wdata_mem = 32'd0;
        mem_op_mem    = OP_W;

        // Reset with a read held: everything low
        @(posedge clk);
        #1;
        exp_q.push_back('{stall: 1'b0, rdata: 32'd0, err: 1'b0});
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        mem_read_mem = 1'b0;
        exp_q.push_back('{stall: 1'b0, rdata: 32'd0, err: 1'b0});

        // Word store then load
        store(32'h0000_1010, 32'hDEAD_BEEF, OP_W);
        load (32'h0000_1010, OP_W, 32'hDEAD_BEEF);

        // Byte store and byte/word reads
        store(32'h0000_1011, 32'h0000_0080, OP_B);
        load (32'h0000_1011, OP_B,  32'hFFFF_FF80);
        load (32'h0000_1011, OP_BU, 32'h0000_0080);
        load (32'h0000_1010, OP_W,  32'hDEAD_80EF);

        // Half store, then three back-to-back loads
        store(32'h0000_1012, 32'h0000_1234, OP_H);
        load (32'h0000_1012, OP_HU, 32'h0000_1234);
        load (32'h0000_1010, OP_W,  32'h1234_80EF);
        load (32'h0000_1010, OP_H,  32'hFFFF_80EF);
        load (32'h0000_1013, OP_B,  32'h0000_0012);
        load (32'h0000_1010, OP_HU, 32'h0000_80EF);
        idle();

        // Top word of the array
        store(32'h0000_10FC, 32'h0102_0304, OP_W);
        load (32'h0000_10FE, OP_H,  32'h0000_0102);
        load (32'h0000_10FC, OP_W,  32'h0102_0304);

        // Illegal accesses
        store(32'h0000_1000, 32'hA5A5_5A5A, OP_W);
        bad  (1'b1, 1'b0, 32'h0000_1002, 32'd0, OP_W);
        idle();
        bad  (1'b0, 1'b1, 32'h0000_1001, 32'h0000_FFFF, OP_H);
        load (32'h0000_1000, OP_W, 32'hA5A5_5A5A);
        bad  (1'b1, 1'b0, 32'h0000_1100, 32'd0, OP_W);
        bad  (1'b1, 1'b0, 32'h0000_0FFC, 32'd0, OP_W);
        bad  (1'b1, 1'b0, 32'h0000_1010, 32'd0, OP_X);
        bad  (1'b0, 1'b1, 32'h0000_1010, 32'd0, OP_BU);
        bad  (1'b1, 1'b1, 32'h0000_1010, 32'd0, OP_W);
        bad  (1'b0, 1'b1, 32'h0000_1013, 32'd0, OP_HU);
        idle();
        load (32'h0000_1010, OP_W, 32'h1234_80EF);

        // Reset during the RESP cycle of a load
        cyc(1'b1, 1'b0, 32'h0000_1010, 32'd0, OP_W, 1'b1, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.push_back('{stall: 1'b0, rdata: 32'd0, err: 1'b0});
        pend_err = 1'b0;
        @(posedge clk);
        #1;
        mem_read_mem = 1'b0;
        exp_q.push_back('{stall: 1'b0, rdata: 32'd0, err: 1'b0});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back('{stall: 1'b0, rdata: 32'd0, err: 1'b0});
        load (32'h0000_1010, OP_W, 32'h1234_80EF);
        idle();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: got no completion expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
